spdif_subframe_ctrl: RTL and testbench
======================================

// Module: spdif_subframe_ctrl
// PURPOSE
//  Sequences the S/PDIF edge-detector outputs (zero/one/head/shift-enable pulses) into
//  32-slot subframes: frames slots 4..31 after each preamble, assembles 24-bit samples,
//  checks parity, and tracks link lock. Sits between edge_detector and the sample sink.
// PARAMETERS
//  LOCK_COUNT   4    consecutive good subframes needed to enter LOCK
//  TIMEOUT_CYC  256  i_clk cycles without head/bit event before framing error
//  TO_W         9    timeout counter width (must hold TIMEOUT_CYC)
// PORTS
//  i_clk         in   1   single system clock, all logic on rising edge
//  i_rst_n       in   1   asynchronous, active-low reset
//  i_zero        in   1   decoded-0 pulse from edge detector
//  i_one         in   1   decoded-1 pulse from edge detector
//  i_head        in   1   preamble-complete pulse (next bit is slot 4)
//  i_shift_ena   in   1   qualifies i_zero/i_one as a bit event
//  o_sample      out  24  slots 4..27, slot 4 = bit 0 (aux LSB .. audio MSB)
//  o_vbit        out  1   validity bit (slot 28)
//  o_ubit        out  1   user bit (slot 29)
//  o_cbit        out  1   channel-status bit (slot 30)
//  o_chan        out  1   0 = subframe A, 1 = subframe B
//  o_strobe      out  1   1-cycle pulse: o_sample/o_*bit/o_chan/o_perr valid
//  o_perr        out  1   even-parity failure over slots 4..31, valid with o_strobe
//  o_locked      out  1   high while FSM in LOCK
//  o_err         out  1   1-cycle pulse on any framing error
// BEHAVIOUR
//  Reset: all outputs 0; FSM=HUNT; bit count, good count, timeout count = 0.
//  Bit event: i_shift_ena & (i_zero ^ i_one); value = i_one. i_shift_ena with both
//   or neither asserted = illegal -> framing error (in SYNC/LOCK; ignored in HUNT).
//  i_head takes priority: a bit event in the same cycle is discarded, no error.
//  FSM states:
//   HUNT: ignore bits. i_head -> SYNC, bitcnt=0, o_chan next subframe = A(0).
//   SYNC: shift bits LSB-first, bitcnt 0..27. On 28th bit -> emit subframe; if parity
//    good increment goodcnt, else goodcnt=0. goodcnt==LOCK_COUNT -> LOCK.
//   LOCK: as SYNC; parity errors flag o_perr only, stay in LOCK.
//  Subframe emit: o_strobe in the cycle after the 28th bit is accepted; data held
//   until next strobe. o_chan toggles after every emitted subframe. o_strobe is
//   asserted in SYNC and LOCK alike.
//  After 28 bits, wait for i_head (bitcnt saturates at 28). i_head -> bitcnt=0.
//  Framing errors (SYNC or LOCK) -> o_err pulse next cycle, goodcnt=0, -> HUNT:
//   i_head with 0 < bitcnt < 28 (short subframe);
//   bit event with bitcnt==28 (long subframe, no preamble);
//   illegal event (above); timeout counter reaches TIMEOUT_CYC.
//  i_head with bitcnt==0 (duplicate head) is harmless: restart, no error.
//  Timeout counter clears on any i_head or bit event and in HUNT; saturates.
//  A framing error never produces o_strobe for the partial subframe.
//  o_locked = (state==LOCK), registered. Reset mid-subframe: immediate return to
//   reset values, partial data discarded.
// TESTING
//  1. Reset, then head + 28 bits encoding sample 24'hA5A5A5, V=0,U=1,C=0, P even ->
//     o_strobe 1 cycle after bit 28, o_sample=A5A5A5, o_ubit=1, o_perr=0, o_chan=0.
//  2. 4 good subframes -> o_locked rises after 4th strobe; o_chan sequence 0,1,0,1.
//  3. In LOCK, subframe with parity bit flipped -> o_strobe, o_perr=1, o_locked stays 1.
//  4. In LOCK, i_head after 15 bits -> o_err pulse, o_locked=0, no strobe; next head
//     re-enters SYNC.
//  5. In SYNC, no events for 256 cycles -> o_err pulse at cycle 256, FSM HUNT.
//  6. i_zero & i_one & i_shift_ena in SYNC -> o_err; assert i_rst_n=0 mid-subframe ->
//     all outputs 0 asynchronously, no strobe afterwards until fresh head + 28 bits.

Source files
------------

// File: rtl/spdif_subframe_ctrl.sv
// S/PDIF subframe sequencer: frames slots 4..31 after each preamble, assembles the
// 24-bit sample plus V/U/C bits, checks even parity and tracks link lock.
module spdif_subframe_ctrl #(
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned TO_W        = 9
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_zero,
  input  logic        i_one,
  input  logic        i_head,
  input  logic        i_shift_ena,
  output logic [23:0] o_sample,
  output logic        o_vbit,
  output logic        o_ubit,
  output logic        o_cbit,
  output logic        o_chan,
  output logic        o_strobe,
  output logic        o_perr,
  output logic        o_locked,
  output logic        o_err
);

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

  logic [1:0]      state_q, state_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [27:0]     shreg_q, shreg_d;
  logic [GW-1:0]   good_cnt_q, good_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            chan_q, chan_d;

  logic        bit_ev;
  logic        illegal;
  logic        emit;
  logic        frame_err;
  logic        par_ok;
  logic [27:0] word;

  assign bit_ev  = i_shift_ena & (i_zero ^ i_one);
  assign illegal = i_shift_ena & ~(i_zero ^ i_one);
  // LSB-first: each new bit enters at the top, so after 28 bits slot 4 sits at bit 0.
  assign word    = {i_one, shreg_q[27:1]};
  assign par_ok  = ~^word;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    good_cnt_d = good_cnt_q;
    to_cnt_d   = to_cnt_q;
    chan_d     = chan_q;
    emit       = 1'b0;
    frame_err  = 1'b0;

    case (state_q)
      HUNT: begin
        to_cnt_d = '0;
        if (i_head) begin
          state_d   = SYNC;
          bit_cnt_d = '0;
          chan_d    = 1'b0;
        end
      end
      SYNC, LOCK: begin
        if (to_cnt_q != TO_W'(TIMEOUT_CYC)) to_cnt_d = to_cnt_q + 1'b1;
        if (i_head) begin
          to_cnt_d = '0;
          if (bit_cnt_q != 5'd0 && bit_cnt_q != 5'd28) frame_err = 1'b1;
          else bit_cnt_d = '0;
        end else if (illegal) begin
          frame_err = 1'b1;
        end else if (bit_ev) begin
          to_cnt_d = '0;
          if (bit_cnt_q == 5'd28) begin
            frame_err = 1'b1;
          end else begin
            shreg_d   = word;
            bit_cnt_d = bit_cnt_q + 5'd1;
            emit      = (bit_cnt_q == 5'd27);
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          frame_err = 1'b1;
        end

        if (emit) begin
          chan_d = ~chan_q;
          if (state_q == SYNC) begin
            if (par_ok) begin
              good_cnt_d = good_cnt_q + 1'b1;
              if (good_cnt_q == GW'(LOCK_COUNT - 1)) state_d = LOCK;
            end else begin
              good_cnt_d = '0;
            end
          end
        end

        if (frame_err) begin
          state_d    = HUNT;
          good_cnt_d = '0;
          bit_cnt_d  = '0;
          to_cnt_d   = '0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= HUNT;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      good_cnt_q <= '0;
      to_cnt_q   <= '0;
      chan_q     <= 1'b0;
      o_sample   <= '0;
      o_vbit     <= 1'b0;
      o_ubit     <= 1'b0;
      o_cbit     <= 1'b0;
      o_chan     <= 1'b0;
      o_strobe   <= 1'b0;
      o_perr     <= 1'b0;
      o_locked   <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      good_cnt_q <= good_cnt_d;
      to_cnt_q   <= to_cnt_d;
      chan_q     <= chan_d;
      o_strobe   <= emit;
      o_err      <= frame_err;
      o_locked   <= (state_d == LOCK);
      if (emit) begin
        o_sample <= word[23:0];
        o_vbit   <= word[24];
        o_ubit   <= word[25];
        o_cbit   <= word[26];
        o_perr   <= ~par_ok;
        o_chan   <= chan_q;
      end
    end
  end

endmodule

// File: tb/tb_spdif_subframe_ctrl.sv
// Directed-sequence bench for spdif_subframe_ctrl with randomized data and gaps,
// checked against a subframe-level model of framing, lock and channel alternation.
module tb_spdif_subframe_ctrl;

  localparam int LOCK_COUNT  = 4;
  localparam int TIMEOUT_CYC = 256;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_zero = 1'b0, i_one = 1'b0, i_head = 1'b0, i_shift_ena = 1'b0;
  logic [23:0] o_sample;
  logic        o_vbit, o_ubit, o_cbit, o_chan, o_strobe, o_perr, o_locked, o_err;

  int checks = 0, errors = 0;
  int strobes = 0, errs = 0;
  int m_strobes = 0, m_errs = 0, m_good = 0;
  bit m_locked = 1'b0, m_hunt = 1'b1, m_chan = 1'b0;

  spdif_subframe_ctrl #(
    .LOCK_COUNT (LOCK_COUNT),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (9)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_zero     (i_zero),
    .i_one      (i_one),
    .i_head     (i_head),
    .i_shift_ena(i_shift_ena),
    .o_sample   (o_sample),
    .o_vbit     (o_vbit),
    .o_ubit     (o_ubit),
    .o_cbit     (o_cbit),
    .o_chan     (o_chan),
    .o_strobe   (o_strobe),
    .o_perr     (o_perr),
    .o_locked   (o_locked),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at a negedge; outputs are read at the following negedge.
  task automatic step(input logic h, input logic e, input logic z, input logic o);
    i_head = h; i_shift_ena = e; i_zero = z; i_one = o;
    @(negedge i_clk);
    if (o_strobe) strobes++;
    if (o_err) errs++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic b);
    step(1'b0, 1'b1, ~b, b);
  endtask

  task automatic send_head();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    if (m_hunt) begin
      m_hunt = 1'b0;
      m_chan = 1'b0;
    end
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 2));
      send_bit(1'($urandom));
    end
  endtask

  function automatic logic [27:0] make_word(input logic [23:0] s, input logic v,
                                            input logic u, input logic c, input logic bad);
    logic p;
    p = (^{c, u, v, s}) ^ bad;
    return {p, c, u, v, s};
  endfunction

  function automatic logic [27:0] rand_word(input logic bad);
    return make_word(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), bad);
  endfunction

  task automatic send_frame(input logic [27:0] w, input string tag);
    logic perr;
    send_head();
    for (int i = 0; i < 28; i++) begin
      if (i > 0) idle($urandom_range(0, 2));
      send_bit(w[i]);
    end
    perr = ^w;
    if (!m_locked) begin
      m_good = perr ? 0 : m_good + 1;
      if (m_good == LOCK_COUNT) m_locked = 1'b1;
    end
    m_strobes++;
    chk({tag, ".strobe"}, 32'(o_strobe), 32'd1);
    chk({tag, ".sample"}, 32'(o_sample), 32'(w[23:0]));
    chk({tag, ".vuc"}, 32'({o_vbit, o_ubit, o_cbit}), 32'({w[24], w[25], w[26]}));
    chk({tag, ".perr"}, 32'(o_perr), 32'(perr));
    chk({tag, ".chan"}, 32'(o_chan), 32'(m_chan));
    m_chan = ~m_chan;
    idle(1);
    chk({tag, ".strobe_pulse"}, 32'(o_strobe), 32'd0);
    chk({tag, ".locked"}, 32'(o_locked), 32'(m_locked));
    chk({tag, ".nstrobes"}, 32'(strobes), 32'(m_strobes));
  endtask

  task automatic expect_err(input string tag);
    m_locked = 1'b0;
    m_good   = 0;
    m_hunt   = 1'b1;
    m_errs++;
    chk({tag, ".err"}, 32'(o_err), 32'd1);
    chk({tag, ".locked"}, 32'(o_locked), 32'd0);
    idle(1);
    chk({tag, ".err_pulse"}, 32'(o_err), 32'd0);
    chk({tag, ".nerrs"}, 32'(errs), 32'(m_errs));
    chk({tag, ".nstrobes"}, 32'(strobes), 32'(m_strobes));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".sample"}, 32'(o_sample), 32'd0);
    chk({tag, ".bits"}, 32'({o_vbit, o_ubit, o_cbit, o_chan, o_perr}), 32'd0);
    chk({tag, ".ctl"}, 32'({o_strobe, o_locked, o_err}), 32'd0);
  endtask

  initial begin
    i_rst_n = 1'b1;
    #1 i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst_n = 1'b1;
    idle(2);

    send_frame(make_word(24'hA5A5A5, 1'b0, 1'b1, 1'b0, 1'b0), "t1");

    // Three more good subframes complete the lock run.
    for (int k = 0; k < 3; k++) send_frame(rand_word(1'b0), "t2");
    chk("t2.locked_final", 32'(o_locked), 32'd1);

    send_frame(rand_word(1'b1), "t3");

    send_head();
    send_bits(15);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_err("t4");
    send_frame(rand_word(1'b0), "t4.resync");

    send_head();
    send_bits(5);
    for (int n = 1; n < TIMEOUT_CYC; n++) begin
      idle(1);
      chk("t5.no_err_yet", 32'(o_err), 32'd0);
    end
    idle(1);
    expect_err("t5.timeout");

    send_head();
    send_bits(10);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    expect_err("t6.illegal");

    for (int k = 0; k < LOCK_COUNT; k++) send_frame(rand_word(1'b0), "t6.relock");
    send_head();
    send_bits(10);
    #2 i_rst_n = 1'b0;
    #1 chk_all_zero("t6.async_rst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_locked = 1'b0;
    m_good   = 0;
    m_hunt   = 1'b1;
    send_bits(30);
    chk("t6.hunt_ignores", 32'(strobes), 32'(m_strobes));
    chk("t6.hunt_locked", 32'(o_locked), 32'd0);
    send_frame(rand_word(1'b0), "t6.fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
